max_pool1: RTL

- 2x2, stride-2 max-pooling stage directly downstream of the first convolution layer.
- Consumes the conv1 output stream: one non-negative (ReLU-clamped) value per valid cycle, raster order, IN_WIDTH x IN_WIDTH per frame.
- Emits an OUT_WIDTH x OUT_WIDTH pooled feature map in raster order to the next layer.
- Odd trailing row/column is discarded (floor pooling).

---
 rtl/max_pool1_pkg.sv | 10 +
 rtl/max_pool1_row_buffer.sv | 29 ++
 rtl/max_pool1.sv | 88 ++++++++
 3 files changed

// File: rtl/max_pool1_pkg.sv
// Shared sizing constants for the first pooling stage, kept in step with the
// conv1 output word width.
package max_pool1_pkg;

  localparam int CONV1_OUT_W  = 32;
  localparam int POOL1_IN_W   = 21;
  localparam int POOL1_OUT_W  = POOL1_IN_W / 2;
  localparam int POOL1_DATA_W = CONV1_OUT_W;

endpackage

// File: rtl/max_pool1_row_buffer.sv
// Holds the horizontal maxima of the top row of each 2x2 window until the
// bottom row arrives. Synchronous write, asynchronous read.
module max_pool1_row_buffer #(
  parameter int DEPTH  = 10,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/max_pool1.sv
// 2x2 stride-2 max pooling over a raster-order stream; odd trailing row and
// column are consumed but never contribute to an output.
module max_pool1
  import max_pool1_pkg::*;
#(
  parameter int IN_WIDTH = POOL1_IN_W,
  parameter int DATA_W   = POOL1_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pool_data_in,
  input  logic              pool_data_in_valid,
  input  logic              img_in_en,
  output logic [DATA_W-1:0] pool_data_out,
  output logic              pool_data_out_valid,
  output logic              pool_frame_done
);

  localparam int OUT_WIDTH = IN_WIDTH / 2;
  localparam int CW        = $clog2(IN_WIDTH);
  localparam int AW        = $clog2(OUT_WIDTH);
  localparam logic [CW-1:0] POOL_LIM = CW'(2 * OUT_WIDTH);
  localparam logic [CW-1:0] LAST_WIN = CW'(2 * OUT_WIDTH - 1);
  localparam logic [CW-1:0] LAST_PIX = CW'(IN_WIDTH - 1);

  logic [CW-1:0]     col_cnt, row_cnt;
  logic [DATA_W-1:0] hold, hmax, rb_data, vmax;
  logic              acc, col_in, row_in, pair_done, rb_wr, emit;
  logic [AW-1:0]     rb_addr;

  // Valid/no-ready contract: a word moves only when pool_data_in_valid and
  // img_in_en are both high; each output strobe lasts one cycle and must be taken.
  assign acc       = pool_data_in_valid & img_in_en;
  assign col_in    = col_cnt < POOL_LIM;
  assign row_in    = row_cnt < POOL_LIM;
  assign pair_done = acc & col_in & col_cnt[0];
  assign rb_wr     = pair_done & row_in & ~row_cnt[0];
  assign emit      = pair_done & row_in & row_cnt[0];
  assign rb_addr   = AW'(col_cnt >> 1);
  assign hmax      = (pool_data_in > hold) ? pool_data_in : hold;
  assign vmax      = (rb_data > hmax) ? rb_data : hmax;

  max_pool1_row_buffer #(
    .DEPTH  (OUT_WIDTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_row_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rb_wr),
    .wr_addr (rb_addr),
    .wr_data (hmax),
    .rd_addr (rb_addr),
    .rd_data (rb_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt             <= '0;
      row_cnt             <= '0;
      hold                <= '0;
      pool_data_out       <= '0;
      pool_data_out_valid <= 1'b0;
      pool_frame_done     <= 1'b0;
    end else begin
      pool_data_out_valid <= 1'b0;
      pool_frame_done     <= 1'b0;
      if (!img_in_en) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end else if (pool_data_in_valid) begin
        if (col_cnt == LAST_PIX) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == LAST_PIX) ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
        if (col_in && !col_cnt[0]) hold <= pool_data_in;
        if (emit) begin
          pool_data_out       <= vmax;
          pool_data_out_valid <= 1'b1;
          pool_frame_done     <= (row_cnt == LAST_WIN) && (col_cnt == LAST_WIN);
        end
      end
    end
  end

endmodule
